// File: rtl/rv32_div_sequencer_pkg.sv
// rtl/rv32_div_sequencer_pkg.sv - shared divide-unit types, writeback source and constants
package rv32_div_sequencer_pkg;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'd0,
        DIV_OP_DIVU = 2'd1,
        DIV_OP_REM  = 2'd2,
        DIV_OP_REMU = 2'd3
    } div_op_t;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_BUSY,
        DIV_DONE
    } div_state_t;

    typedef enum logic [1:0] {
        WB_ALU,
        WB_MEM,
        WB_PC4,
        WB_DIV
    } wb_src_t;

    // Decoded-instruction fields that steer an instruction into the divider
    typedef struct packed {
        logic    use_div;
        div_op_t div_op;
        wb_src_t wb_src;
    } div_decode_t;

    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] DIV_OVF_Q  = 32'h8000_0000;

    function automatic logic op_is_signed(div_op_t op);
        return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    endfunction

    function automatic logic op_is_rem(div_op_t op);
        return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
    endfunction

    function automatic logic [31:0] abs32(logic [31:0] v);
        return v[31] ? -v : v;
    endfunction

endpackage

// File: rtl/rv32_div_sequencer_if.sv
// rtl/rv32_div_sequencer_if.sv - exec-stage to divide-unit handshake bundle
interface rv32_div_sequencer_if;
    import rv32_div_sequencer_pkg::*;

    logic        start;
    div_op_t     op;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        flush;
    logic        stall;
    logic        result_valid;
    logic [31:0] result;

    modport master (
        output start, op, op1, op2, flush,
        input  stall, result_valid, result
    );

    modport slave (
        input  start, op, op1, op2, flush,
        output stall, result_valid, result
    );
endinterface

// File: rtl/rv32_div_step.sv
// rtl/rv32_div_step.sv - one combinational restoring-division step on {remainder, quotient}
module rv32_div_step (
    input  logic [31:0] rem_i,
    input  logic [31:0] quo_i,
    input  logic [31:0] divisor,
    output logic [31:0] rem_o,
    output logic [31:0] quo_o
);
    logic [32:0] shifted;
    logic        fits;

    // Remainder stays below the divisor, so the shifted trial value needs only 33 bits
    assign shifted = {rem_i, quo_i[31]};
    assign fits    = shifted >= {1'b0, divisor};
    assign rem_o   = fits ? 32'(shifted - {1'b0, divisor}) : shifted[31:0];
    assign quo_o   = {quo_i[30:0], fits};
endmodule

// File: rtl/rv32_div_sequencer.sv
// rtl/rv32_div_sequencer.sv - iterative RV32M DIV/DIVU/REM/REMU unit with exec-stage stall control
module rv32_div_sequencer
    import rv32_div_sequencer_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    rv32_div_sequencer_if.slave  bus
);
    localparam int          ITERS = 32 / BITS_PER_CYCLE;
    localparam logic [4:0]  LAST  = 5'(ITERS - 1);

    div_state_t  state, state_next;
    logic [4:0]  count;
    div_op_t     op_q;
    logic        neg_q, neg_r;
    logic [31:0] rem_q, quo_q, dsr_q, result_q;

    logic        accept, special;
    logic [31:0] special_res, final_q, final_r, final_res;
    logic [31:0] rem_c [0:BITS_PER_CYCLE];
    logic [31:0] quo_c [0:BITS_PER_CYCLE];

    assign accept  = bus.start && !bus.flush;
    assign special = (bus.op2 == 32'd0) ||
                     (op_is_signed(bus.op) && bus.op1 == DIV_OVF_Q && bus.op2 == 32'hFFFF_FFFF);

    always_comb begin
        special_res = 32'd0;
        if (bus.op2 == 32'd0) special_res = op_is_rem(bus.op) ? bus.op1 : DIV_ZERO_Q;
        else                  special_res = op_is_rem(bus.op) ? 32'd0   : DIV_OVF_Q;
    end

    assign rem_c[0] = rem_q;
    assign quo_c[0] = quo_q;
    for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
        rv32_div_step u_step (
            .rem_i   (rem_c[g]),
            .quo_i   (quo_c[g]),
            .divisor (dsr_q),
            .rem_o   (rem_c[g+1]),
            .quo_o   (quo_c[g+1])
        );
    end

    assign final_q   = neg_q ? -quo_c[BITS_PER_CYCLE] : quo_c[BITS_PER_CYCLE];
    assign final_r   = neg_r ? -rem_c[BITS_PER_CYCLE] : rem_c[BITS_PER_CYCLE];
    assign final_res = op_is_rem(op_q) ? final_r : final_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= DIV_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            DIV_IDLE: if (accept) state_next = special ? DIV_DONE : DIV_BUSY;
            DIV_BUSY: begin
                if (bus.flush)          state_next = DIV_IDLE;
                else if (count == LAST) state_next = DIV_DONE;
            end
            DIV_DONE: state_next = DIV_IDLE;
            default:  state_next = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count    <= 5'd0;
            op_q     <= DIV_OP_DIV;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            rem_q    <= 32'd0;
            quo_q    <= 32'd0;
            dsr_q    <= 32'd0;
            result_q <= 32'd0;
        end else begin
            case (state)
                DIV_IDLE: if (accept) begin
                    op_q  <= bus.op;
                    neg_q <= op_is_signed(bus.op) && (bus.op1[31] ^ bus.op2[31]);
                    neg_r <= op_is_signed(bus.op) && bus.op1[31];
                    rem_q <= 32'd0;
                    quo_q <= op_is_signed(bus.op) ? abs32(bus.op1) : bus.op1;
                    dsr_q <= op_is_signed(bus.op) ? abs32(bus.op2) : bus.op2;
                    count <= 5'd0;
                    if (special) result_q <= special_res;
                end
                DIV_BUSY: begin
                    rem_q <= rem_c[BITS_PER_CYCLE];
                    quo_q <= quo_c[BITS_PER_CYCLE];
                    count <= count + 5'd1;
                    if (count == LAST && !bus.flush) result_q <= final_res;
                end
                default: ;
            endcase
        end
    end

    // DONE drops stall so the exec buffer captures the result this cycle
    assign bus.stall        = (state == DIV_IDLE && accept) || (state == DIV_BUSY);
    assign bus.result_valid = (state == DIV_DONE);
    assign bus.result       = result_q;
endmodule

// File: tb/tb_rv32_div_sequencer.sv
// tb/tb_rv32_div_sequencer.sv - self-checking bench for rv32_div_sequencer
module tb_rv32_div_sequencer;
    import rv32_div_sequencer_pkg::*;

    localparam int BPC   = 1;
    localparam int ITERS = 32 / BPC;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    rv32_div_sequencer_if bus();

    rv32_div_sequencer #(.BITS_PER_CYCLE(BPC)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        div_op_t     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          special;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic bit is_special(div_op_t op, logic [31:0] a, logic [31:0] b);
        return (b == 0) || ((op == DIV_OP_DIV || op == DIV_OP_REM) &&
                            a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] model(div_op_t op, logic [31:0] a, logic [31:0] b);
        int sa, sb;
        sa = int'(a);
        sb = int'(b);
        case (op)
            DIV_OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            DIV_OP_REMU: return (b == 0) ? a : a % b;
            DIV_OP_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            default: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
        endcase
    endfunction

    // Called just after a rising edge; holds start until the result strobe, then releases it
    task automatic run_op(input div_op_t op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output bit stall_ok);
        bus.start = 1'b1;
        bus.op    = op;
        bus.op1   = a;
        bus.op2   = b;
        lat       = -1;
        res       = 32'hDEAD_BEEF;
        stall_ok  = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.result_valid === 1'b1) begin
                lat = c;
                res = bus.result;
                if (bus.stall !== 1'b0) stall_ok = 1'b0;
                break;
            end else if (bus.stall !== 1'b1) begin
                stall_ok = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic do_check(input string tag, input div_op_t op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp, input bit special);
        logic [31:0] res;
        int          lat;
        bit          stall_ok;
        run_op(op, a, b, res, lat, stall_ok);
        check({tag, " result"}, res, exp);
        check({tag, " latency"}, 32'(lat), special ? 32'd1 : 32'(ITERS + 1));
        check({tag, " stall"}, 32'(stall_ok), 32'd1);
    endtask

    initial begin
        int          nv;
        div_op_t     rop;
        logic [31:0] ra, rb;

        vecs[0]  = '{DIV_OP_DIVU, 32'd100,        32'd7,          32'd14,         1'b0};
        vecs[1]  = '{DIV_OP_REMU, 32'd100,        32'd7,          32'd2,          1'b0};
        vecs[2]  = '{DIV_OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0};
        vecs[3]  = '{DIV_OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0};
        vecs[4]  = '{DIV_OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  1'b0};
        vecs[5]  = '{DIV_OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          1'b0};
        vecs[6]  = '{DIV_OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1};
        vecs[7]  = '{DIV_OP_REMU, 32'd5,          32'd0,          32'd5,          1'b1};
        vecs[8]  = '{DIV_OP_REM,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  1'b1};
        vecs[9]  = '{DIV_OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1};
        vecs[10] = '{DIV_OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1};
        vecs[11] = '{DIV_OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b1};
        vecs[12] = '{DIV_OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0};
        vecs[13] = '{DIV_OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0};
        vecs[14] = '{DIV_OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0};
        vecs[15] = '{DIV_OP_DIV,  32'h8000_0000,  32'd1,          32'h8000_0000,  1'b0};

        resetn    = 1'b0;
        bus.start = 1'b0;
        bus.op    = DIV_OP_DIV;
        bus.op1   = 32'd0;
        bus.op2   = 32'd0;
        bus.flush = 1'b0;
        repeat (2) @(negedge clk);
        check("reset result_valid", 32'(bus.result_valid), 32'd0);
        check("reset result", bus.result, 32'd0);
        check("reset stall", 32'(bus.stall), 32'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i])
            do_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                     vecs[i].exp, vecs[i].special);

        // Flush in BUSY cycle 10 kills the operation
        bus.start = 1'b1;
        bus.op    = DIV_OP_DIVU;
        bus.op1   = 32'd100;
        bus.op2   = 32'd7;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        @(negedge clk);
        check("flush_busy stall", 32'(bus.stall), 32'd0);
        nv = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.result_valid === 1'b1) nv++;
        end
        check("flush_busy no valid", 32'(nv), 32'd0);
        @(posedge clk);
        #1;
        do_check("after_flush", DIV_OP_DIVU, 32'd9, 32'd3, 32'd3, 1'b0);

        // Flush alongside start in IDLE: nothing is accepted
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.op    = DIV_OP_DIV;
        bus.op1   = 32'd5;
        bus.op2   = 32'd0;
        #1;
        check("flush_idle stall", 32'(bus.stall), 32'd0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        @(negedge clk);
        check("flush_idle no valid", 32'(bus.result_valid), 32'd0);
        @(posedge clk);
        #1;

        // Asynchronous reset mid-BUSY, then back-to-back ops
        bus.start = 1'b1;
        bus.op    = DIV_OP_DIVU;
        bus.op1   = 32'd100;
        bus.op2   = 32'd7;
        repeat (6) @(posedge clk);
        #1;
        bus.start = 1'b0;
        #1;
        resetn = 1'b0;
        #1;
        check("midreset result_valid", 32'(bus.result_valid), 32'd0);
        check("midreset result", bus.result, 32'd0);
        check("midreset stall", 32'(bus.stall), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        do_check("b2b first", DIV_OP_DIVU, 32'd20, 32'd4, 32'd5, 1'b0);
        do_check("b2b second", DIV_OP_DIVU, 32'd21, 32'd4, 32'd5, 1'b0);

        for (int i = 0; i < 150; i++) begin
            rop = div_op_t'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom >> $urandom_range(0, 31);
            case ($urandom_range(0, 9))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: begin
                    ra = 32'($signed($urandom_range(0, 40)) - 20);
                    rb = 32'($signed($urandom_range(0, 10)) - 5);
                end
                default: ;
            endcase
            do_check($sformatf("rand%0d", i), rop, ra, rb, model(rop, ra, rb),
                     is_special(rop, ra, rb));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
